// File: rtl/quadencoderz_filt_if.sv
// Pin-side and host-side signals of the quadrature encoder block.
// The master drives encoder pins and host controls; the slave is the decoder.
interface quadencoderz_filt_if #(
  parameter int BITS     = 32,
  parameter int ERR_BITS = 8
);
  logic                a;
  logic                b;
  logic                z;
  logic                indexenable;
  logic                error_clr;
  logic                indexout;
  logic [BITS-1:0]     position;
  logic [BITS-1:0]     index_pos;
  logic                index_valid;
  logic [ERR_BITS-1:0] error_count;

  modport master (
    output a, b, z, indexenable, error_clr,
    input  indexout, position, index_pos, index_valid, error_count
  );

  modport slave (
    input  a, b, z, indexenable, error_clr,
    output indexout, position, index_pos, index_valid, error_count
  );
endinterface

// File: rtl/quadencoderz_filt.sv
// Quadrature A/B/Z decoder: synchronize, glitch-filter, count, index capture/clear.
// Pin change reaches the count after 2 + FILTER + 1 cycles; no backpressure (free-running).
module quadencoderz_filt #(
  parameter int BITS      = 32,
  parameter int QUAD_TYPE = 0,
  parameter int FILTER    = 3,
  parameter int ERR_BITS  = 8
) (
  input  logic               clk,
  input  logic               rst,
  quadencoderz_filt_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, WAIT} idx_state_t;

  // Bit order everywhere in the input path: [2]=A, [1]=B, [0]=Z.
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] filt;
  logic [2:0] prev_q, prev_d;

  always_comb begin
    sync1_d = {bus.a, bus.b, bus.z};
    sync2_d = sync1_q;
    prev_d  = filt;
  end

  generate
    if (FILTER > 0) begin : g_filt
      localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
      logic [2:0]    filt_q, filt_d;
      logic [CW-1:0] run_q [3];
      logic [CW-1:0] run_d [3];

      // run counts consecutive cycles the synchronized input has disagreed with filt_q
      always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
          run_d[i] = '0;
          if (sync2_q[i] != filt_q[i]) begin
            if (run_q[i] == CW'(FILTER - 1)) begin
              filt_d[i] = sync2_q[i];
            end else begin
              run_d[i] = run_q[i] + CW'(1);
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          filt_q <= '0;
          for (int i = 0; i < 3; i++) begin
            run_q[i] <= '0;
          end
        end else begin
          filt_q <= filt_d;
          run_q  <= run_d;
        end
      end

      assign filt = filt_q;
    end else begin : g_bypass
      assign filt = sync2_q;
    end
  endgenerate

  logic [1:0] ab_now, ab_prev, ab_diff;
  logic       step, illegal, step_up, z_rise;

  assign ab_now  = filt[2:1];
  assign ab_prev = prev_q[2:1];
  assign ab_diff = ab_now ^ ab_prev;
  assign step    = ^ab_diff;
  assign illegal = &ab_diff;
  assign step_up = ab_prev[1] ^ ab_now[0];
  assign z_rise  = filt[0] & ~prev_q[0];

  idx_state_t                state_q, state_d;
  logic                      indexout_q, indexout_d;
  logic signed [BITS-1:0]    count_q, count_d;
  logic [BITS-1:0]           index_pos_q, index_pos_d;
  logic                      index_valid_q, index_valid_d;
  logic [ERR_BITS-1:0]       err_q, err_d;
  logic                      idx_clear;

  always_comb begin
    state_d       = state_q;
    idx_clear     = 1'b0;
    count_d       = count_q;
    index_pos_d   = index_pos_q;
    index_valid_d = z_rise;
    err_d         = err_q;

    case (state_q)
      IDLE:  if (bus.indexenable) state_d = ARMED;
      ARMED: begin
        if (!bus.indexenable) begin
          state_d = IDLE;
        end else if (z_rise) begin
          idx_clear = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT:    if (!bus.indexenable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    indexout_d = (state_d == ARMED);

    // Capture uses the pre-update count, so it sees neither the clear nor this cycle's step.
    if (z_rise) index_pos_d = count_q;

    if (idx_clear) begin
      count_d = '0;
    end else if (step) begin
      count_d = step_up ? count_q + BITS'(1) : count_q - BITS'(1);
    end

    if (bus.error_clr) begin
      err_d = illegal ? ERR_BITS'(1) : '0;
    end else if (illegal && (err_q != '1)) begin
      err_d = err_q + ERR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      state_q       <= IDLE;
      indexout_q    <= 1'b0;
      count_q       <= '0;
      index_pos_q   <= '0;
      index_valid_q <= 1'b0;
      err_q         <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      indexout_q    <= indexout_d;
      count_q       <= count_d;
      index_pos_q   <= index_pos_d;
      index_valid_q <= index_valid_d;
      err_q         <= err_d;
    end
  end

  assign bus.indexout    = indexout_q;
  assign bus.position    = count_q >>> QUAD_TYPE;
  assign bus.index_pos   = index_pos_q;
  assign bus.index_valid = index_valid_q;
  assign bus.error_count = err_q;

endmodule
